mem_port_arb: RTL and testbench
===============================

MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 imem_cmd_i / imem_addr_i / imem_data_i  input  2/64/64  instruction-fetch requester command (BUS_NONE/LOAD/STORE), address, store data.
REQ-004 dmem_cmd_i / dmem_addr_i / dmem_data_i  input  2/64/64  data-memory-controller requester command, address, store data.
REQ-005 imem_response_o / dmem_response_o  output  4/4  per-requester accept tag; nonzero means accepted this cycle.
REQ-006 imem_tag_o / dmem_tag_o  output  4/4  per-requester returning-data tag; 0 means none.
REQ-007 imem_data_o / dmem_data_o  output  64/64  returning data; equals mem2proc_data_i to both requesters.
REQ-008 proc2mem_command_o / proc2mem_addr_o / proc2mem_data_o  output  2/64/64  single memory port.
REQ-009 mem2proc_response_i / mem2proc_tag_i / mem2proc_data_i  input  4/4/64  memory accept tag, return tag, return data.
REQ-010 outstanding_o  output  4  count of pending load tags.
REQ-011 tag_err_o  output  1  sticky flag: returned tag had no pending owner.

Function
REQ-012 A requester is active when its cmd != BUS_NONE.
REQ-013 Winner selection is combinational, 2-way round-robin; the pointer favours the requester that did not win the last accepted transfer.
REQ-014 Lock rule: if the winner is issued and mem2proc_response_i == 0, the arbiter keeps that requester as winner in following cycles until it is accepted or drops its command.
REQ-015 The memory port is driven from the winner's cmd/addr/data; it is BUS_NONE with addr/data 0 when neither requester is active.
REQ-016 mem2proc_response_i is forwarded to the winner's response output only; the loser's response is 0.
REQ-017 The round-robin pointer updates only in a cycle where mem2proc_response_i != 0.
REQ-018 Tag table: 15 entries (tags 1..15), each holding pending bit and owner bit.
REQ-019 On accept of BUS_LOAD, set pending[response] = 1 and owner[response] = winner; stores are not recorded.
REQ-020 On mem2proc_tag_i != 0 with pending set, drive that tag to the owner's tag output (other requester's tag = 0) and clear pending the same edge.
REQ-021 On mem2proc_tag_i != 0 with pending clear, drive both tag outputs 0 and set tag_err_o.
REQ-022 If return and new accept use the same tag in one cycle, route the return to the old owner; the new set takes priority in the next-state table.
REQ-023 outstanding_o = popcount of pending bits, registered; it increments, decrements, or holds on simultaneous set and clear.
REQ-024 Tag 0 is never recorded or routed.
REQ-025 Latency: issue, accept and return routing are zero-cycle combinational; table state is visible next cycle.

Reset
REQ-026 On rst: pending bits, owner bits, lock, round-robin pointer (favour dmem), outstanding_o and tag_err_o clear to 0.
REQ-027 Assertion mid-transaction discards all pending tags; later returns for them set tag_err_o only after rst is deasserted.
REQ-028 During rst, proc2mem_command_o is BUS_NONE, and all response and tag outputs are 0.

Structure
REQ-029 BUS_NONE/BUS_LOAD/BUS_STORE come from the shared defines; the owner encoding (OWN_IMEM = 0, OWN_DMEM = 1) is added to the shared package.
REQ-030 One sub-module, rr_arb2: two request lines, a lock input, an accept strobe, and a one-hot grant output.

Verification
REQ-031 Both requesters issue LOAD; memory accepts tag 3, then tag 4 -> dmem gets response 3 first, imem gets 4 next cycle, and outstanding_o = 2.
REQ-032 dmem LOAD rejected 3 cycles (response 0) while imem is active -> port holds dmem cmd/addr all 3 cycles; imem response stays 0.
REQ-033 Return tag 4 with data 0xDEADBEEF -> imem_tag_o = 4, imem_data_o = 0xDEADBEEF, dmem_tag_o = 0; outstanding_o drops by 1.
REQ-034 Return tag 9 never issued -> both tags 0 and tag_err_o = 1 until rst.
REQ-035 Same cycle: return tag 5 (owner imem) and dmem LOAD accepted with tag 5 -> imem_tag_o = 5; next cycle pending[5] = 1 with owner dmem.
REQ-036 dmem STORE accepted with tag 2 -> no table entry and outstanding_o unchanged; rst with 3 pending -> outstanding_o = 0 next cycle.

Source files
------------

// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the memory port arbiter slice.
//   bus_cmd_e : memory bus command encoding (BUS_NONE / BUS_LOAD / BUS_STORE)
//   owner_e   : which requester owns an outstanding load tag
//   popcount16: number of set bits in a 16-bit vector
package mem_port_arb_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  typedef enum logic {
    OWN_IMEM = 1'b0,
    OWN_DMEM = 1'b1
  } owner_e;

  localparam int unsigned NUM_TAGS = 16;

  function automatic logic [3:0] popcount16(input logic [15:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/mem_port_arb_if.sv
// Bundle of all requester, memory-port and status signals of mem_port_arb.
//   slave  : view used by the arbiter (requests/memory replies in, port/routing out)
//   master : view used by the environment driving the arbiter
interface mem_port_arb_if;
  import mem_port_arb_pkg::*;

  bus_cmd_e    imem_cmd_i;
  logic [63:0] imem_addr_i;
  logic [63:0] imem_data_i;
  bus_cmd_e    dmem_cmd_i;
  logic [63:0] dmem_addr_i;
  logic [63:0] dmem_data_i;

  logic [3:0]  imem_response_o;
  logic [3:0]  dmem_response_o;
  logic [3:0]  imem_tag_o;
  logic [3:0]  dmem_tag_o;
  logic [63:0] imem_data_o;
  logic [63:0] dmem_data_o;

  bus_cmd_e    proc2mem_command_o;
  logic [63:0] proc2mem_addr_o;
  logic [63:0] proc2mem_data_o;

  logic [3:0]  mem2proc_response_i;
  logic [3:0]  mem2proc_tag_i;
  logic [63:0] mem2proc_data_i;

  logic [3:0]  outstanding_o;
  logic        tag_err_o;

  modport slave (
    input  imem_cmd_i, imem_addr_i, imem_data_i,
    input  dmem_cmd_i, dmem_addr_i, dmem_data_i,
    input  mem2proc_response_i, mem2proc_tag_i, mem2proc_data_i,
    output imem_response_o, dmem_response_o, imem_tag_o, dmem_tag_o,
    output imem_data_o, dmem_data_o,
    output proc2mem_command_o, proc2mem_addr_o, proc2mem_data_o,
    output outstanding_o, tag_err_o
  );

  modport master (
    output imem_cmd_i, imem_addr_i, imem_data_i,
    output dmem_cmd_i, dmem_addr_i, dmem_data_i,
    output mem2proc_response_i, mem2proc_tag_i, mem2proc_data_i,
    input  imem_response_o, dmem_response_o, imem_tag_o, dmem_tag_o,
    input  imem_data_o, dmem_data_o,
    input  proc2mem_command_o, proc2mem_addr_o, proc2mem_data_o,
    input  outstanding_o, tag_err_o
  );
endinterface

// File: rtl/mem_port_arb_rr_arb2.sv
// Two-way round-robin arbiter with grant hold.
//   clk, rst  : clock, synchronous active-high reset
//   req_i     : request lines (bit 0 imem, bit 1 dmem)
//   lock_i    : keep last cycle's grant while that requester still requests
//   accept_i  : the current grant was accepted; advances the round-robin pointer
//   grant_o   : one-hot grant (combinational)
module rr_arb2
  import mem_port_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       lock_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  // Winner of the last accepted transfer; the other side is favoured next.
  owner_e     last_q, last_d;
  logic [1:0] held_q;

  always_comb begin
    grant_o = '0;
    if (lock_i && |(held_q & req_i)) begin
      grant_o = held_q;
    end else if (req_i == 2'b11) begin
      grant_o = (last_q == OWN_DMEM) ? 2'b01 : 2'b10;
    end else begin
      grant_o = req_i;
    end

    last_d = last_q;
    if (accept_i && |grant_o) begin
      last_d = grant_o[1] ? OWN_DMEM : OWN_IMEM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= OWN_IMEM;
      held_q <= '0;
    end else begin
      last_q <= last_d;
      held_q <= grant_o;
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates an instruction-fetch and a data requester onto one memory port
// and routes returning load tags back to the requester that issued them.
//   clk, rst : clock, synchronous active-high reset
//   bus      : requester commands, memory port, memory replies, per-requester
//              accept/return tags, outstanding-load count and sticky tag error
module mem_port_arb
  import mem_port_arb_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  mem_port_arb_if.slave  bus
);

  typedef enum logic {ARB_FREE, ARB_LOCKED} arb_state_e;

  arb_state_e  state_q, state_d;
  logic [1:0]  req, grant;
  logic        issued, accepted;
  logic [15:0] pending_q, pending_d;
  logic [15:0] owner_q, owner_d;   // 1 = OWN_DMEM
  logic        err_q, err_d;
  logic [3:0]  outstanding_q;

  // Requests are masked during reset so the port and all routing stay idle.
  assign req[0] = !rst && (bus.imem_cmd_i != BUS_NONE);
  assign req[1] = !rst && (bus.dmem_cmd_i != BUS_NONE);

  rr_arb2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .lock_i   (state_q == ARB_LOCKED),
    .accept_i (|bus.mem2proc_response_i),
    .grant_o  (grant)
  );

  assign issued   = |grant;
  assign accepted = issued && (bus.mem2proc_response_i != '0);

  always_comb begin
    bus.proc2mem_command_o = BUS_NONE;
    bus.proc2mem_addr_o    = '0;
    bus.proc2mem_data_o    = '0;
    if (grant[0]) begin
      bus.proc2mem_command_o = bus.imem_cmd_i;
      bus.proc2mem_addr_o    = bus.imem_addr_i;
      bus.proc2mem_data_o    = bus.imem_data_i;
    end else if (grant[1]) begin
      bus.proc2mem_command_o = bus.dmem_cmd_i;
      bus.proc2mem_addr_o    = bus.dmem_addr_i;
      bus.proc2mem_data_o    = bus.dmem_data_i;
    end
    bus.imem_response_o = grant[0] ? bus.mem2proc_response_i : '0;
    bus.dmem_response_o = grant[1] ? bus.mem2proc_response_i : '0;

    state_d = (issued && !accepted) ? ARB_LOCKED : ARB_FREE;
  end

  // Return routing reads the current table (old owner); a same-tag accept
  // is applied afterwards so the new entry wins in the next-state table.
  always_comb begin
    pending_d      = pending_q;
    owner_d        = owner_q;
    err_d          = err_q;
    bus.imem_tag_o = '0;
    bus.dmem_tag_o = '0;
    if (!rst && bus.mem2proc_tag_i != '0) begin
      if (pending_q[bus.mem2proc_tag_i]) begin
        if (owner_q[bus.mem2proc_tag_i]) bus.dmem_tag_o = bus.mem2proc_tag_i;
        else                             bus.imem_tag_o = bus.mem2proc_tag_i;
        pending_d[bus.mem2proc_tag_i] = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
    if (accepted && bus.proc2mem_command_o == BUS_LOAD) begin
      pending_d[bus.mem2proc_response_i] = 1'b1;
      owner_d[bus.mem2proc_response_i]   = grant[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_FREE;
      pending_q     <= '0;
      owner_q       <= '0;
      err_q         <= 1'b0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      owner_q       <= owner_d;
      err_q         <= err_d;
      outstanding_q <= popcount16(pending_d);
    end
  end

  assign bus.imem_data_o   = bus.mem2proc_data_i;
  assign bus.dmem_data_o   = bus.mem2proc_data_i;
  assign bus.outstanding_o = outstanding_q;
  assign bus.tag_err_o     = err_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Randomized self-checking bench for mem_port_arb against a behavioural model
// of the arbitration and tag-ownership rules.
module tb_mem_port_arb;
  import mem_port_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arb_if bus ();

  mem_port_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_last     = 0;   // last accepted winner: 0 imem, 1 dmem
  bit m_locked   = 0;
  int m_lock_who = 0;
  bit m_pend[16];
  int m_own[16];
  bit m_err      = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 1; i < 16; i++) if (m_pend[i]) n++;
    return n;
  endfunction

  task automatic step(input bus_cmd_e ic, input logic [63:0] ia, input logic [63:0] id,
                      input bus_cmd_e dc, input logic [63:0] da, input logic [63:0] dd,
                      input logic [3:0] resp, input logic [3:0] rtag,
                      input logic [63:0] rdata, input logic r);
    bit act_i, act_d;
    int w;
    bus_cmd_e    e_cmd;
    logic [63:0] e_addr, e_data;
    logic [3:0]  e_ti, e_td;

    @(negedge clk);
    rst = r;
    bus.imem_cmd_i = ic; bus.imem_addr_i = ia; bus.imem_data_i = id;
    bus.dmem_cmd_i = dc; bus.dmem_addr_i = da; bus.dmem_data_i = dd;
    bus.mem2proc_response_i = resp;
    bus.mem2proc_tag_i      = rtag;
    bus.mem2proc_data_i     = rdata;
    #1;

    act_i = !r && ic != BUS_NONE;
    act_d = !r && dc != BUS_NONE;
    if (m_locked && ((m_lock_who == 0 && act_i) || (m_lock_who == 1 && act_d))) w = m_lock_who;
    else if (act_i && act_d) w = 1 - m_last;
    else if (act_i) w = 0;
    else if (act_d) w = 1;
    else w = -1;

    e_cmd = BUS_NONE; e_addr = '0; e_data = '0;
    if (w == 0) begin e_cmd = ic; e_addr = ia; e_data = id; end
    if (w == 1) begin e_cmd = dc; e_addr = da; e_data = dd; end
    e_ti = '0; e_td = '0;
    if (!r && rtag != 0 && m_pend[rtag]) begin
      if (m_own[rtag] == 0) e_ti = rtag; else e_td = rtag;
    end

    check_eq("port_cmd",  64'(bus.proc2mem_command_o), 64'(e_cmd));
    check_eq("port_addr", bus.proc2mem_addr_o, e_addr);
    check_eq("port_data", bus.proc2mem_data_o, e_data);
    check_eq("imem_resp", 64'(bus.imem_response_o), (w == 0) ? 64'(resp) : 64'd0);
    check_eq("dmem_resp", 64'(bus.dmem_response_o), (w == 1) ? 64'(resp) : 64'd0);
    check_eq("imem_tag",  64'(bus.imem_tag_o), 64'(e_ti));
    check_eq("dmem_tag",  64'(bus.dmem_tag_o), 64'(e_td));
    check_eq("imem_data", bus.imem_data_o, rdata);
    check_eq("dmem_data", bus.dmem_data_o, rdata);

    if (r) begin
      m_last = 0; m_locked = 0; m_err = 0;
      for (int i = 0; i < 16; i++) m_pend[i] = 0;
    end else begin
      if (rtag != 0) begin
        if (m_pend[rtag]) m_pend[rtag] = 0;
        else m_err = 1;
      end
      if (w >= 0 && resp != 0) begin
        m_last = w;
        if (e_cmd == BUS_LOAD) begin
          m_pend[resp] = 1;
          m_own[resp]  = w;
        end
      end
      m_locked   = (w >= 0 && resp == 0);
      m_lock_who = w;
    end

    @(posedge clk);
    #1;
    check_eq("outstanding", 64'(bus.outstanding_o), 64'(model_count()));
    check_eq("tag_err",     64'(bus.tag_err_o), 64'(m_err));
  endtask

  task automatic idle(input logic [3:0] rtag, input logic [63:0] rdata, input logic r);
    step(BUS_NONE, '0, '0, BUS_NONE, '0, '0, 4'd0, rtag, rdata, r);
  endtask

  initial begin
    bus_cmd_e    ic, dc;
    logic [3:0]  resp, rtag;

    rst = 1'b1;
    idle(4'd0, '0, 1'b1);
    idle(4'd0, '0, 1'b1);

    // Both load: dmem favoured after reset (tag 3), then imem (tag 4)
    step(BUS_LOAD, 64'h1000, '0, BUS_LOAD, 64'h2000, '0, 4'd3, 4'd0, '0, 1'b0);
    step(BUS_LOAD, 64'h1000, '0, BUS_NONE, '0, '0, 4'd4, 4'd0, '0, 1'b0);
    idle(4'd0, '0, 1'b0);
    check_eq("two_outstanding", 64'(bus.outstanding_o), 64'd2);

    // Return tag 4 to imem
    idle(4'd4, 64'hDEADBEEF, 1'b0);

    // dmem rejected 3 cycles with imem competing, then accepted with tag 6
    for (int k = 0; k < 3; k++)
      step(BUS_LOAD, 64'h1100, '0, BUS_LOAD, 64'h2008, '0, 4'd0, 4'd0, '0, 1'b0);
    step(BUS_LOAD, 64'h1100, '0, BUS_LOAD, 64'h2008, '0, 4'd6, 4'd0, '0, 1'b0);

    // Tag 5 owned by imem, returned while dmem is accepted with tag 5
    step(BUS_LOAD, 64'h1010, '0, BUS_NONE, '0, '0, 4'd5, 4'd0, '0, 1'b0);
    step(BUS_NONE, '0, '0, BUS_LOAD, 64'h2010, '0, 4'd5, 4'd5, 64'h55, 1'b0);
    idle(4'd5, 64'h66, 1'b0);

    // Unissued tag 9 return: sticky error
    idle(4'd9, 64'h99, 1'b0);
    idle(4'd0, '0, 1'b0);

    // Store is not tracked; then pending loads 3, 6, 7
    step(BUS_NONE, '0, '0, BUS_STORE, 64'h3000, 64'h1234, 4'd2, 4'd0, '0, 1'b0);
    step(BUS_LOAD, 64'h1020, '0, BUS_NONE, '0, '0, 4'd7, 4'd0, '0, 1'b0);
    check_eq("three_pending", 64'(bus.outstanding_o), 64'd3);

    // Reset discards pending tags; late returns flag errors only afterwards
    idle(4'd3, '0, 1'b1);
    check_eq("rst_clears", 64'(bus.outstanding_o), 64'd0);
    idle(4'd0, '0, 1'b0);
    idle(4'd6, '0, 1'b0);
    check_eq("late_return_err", 64'(bus.tag_err_o), 64'd1);

    for (int n = 0; n < 3000; n++) begin
      ic   = bus_cmd_e'($urandom_range(0, 2));
      dc   = bus_cmd_e'($urandom_range(0, 2));
      resp = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      rtag = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      step(ic, {$urandom, $urandom}, {$urandom, $urandom},
           dc, {$urandom, $urandom}, {$urandom, $urandom},
           resp, rtag, {$urandom, $urandom}, ($urandom_range(0, 63) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
